// File: rtl/cacheline_adaptor.sv
// Cache-line to memory burst adaptor: one line-wide read/write becomes a BURST_LEN-beat burst.
// Optional CLADAPT_PMEM_ERROR_EN aborts a burst on pmem_error and reports it via err_o.
module cacheline_adaptor #(
    parameter int BURST_LEN        = 4,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   read_i,
    input  logic                                   write_i,
    input  logic [ADDR_WIDTH-1:0]                  address_i,
    input  logic [CACHE_LINE_WIDTH-1:0]            line_i,
    output logic [CACHE_LINE_WIDTH-1:0]            line_o,
    output logic                                   resp_o,
    output logic                                   err_o,
    output logic                                   pmem_read,
    output logic                                   pmem_write,
    output logic [ADDR_WIDTH-1:0]                  pmem_addr,
    output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]  pmem_wdata,
    input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]  pmem_rdata,
    input  logic                                   pmem_resp,
    input  logic                                   pmem_error
);
    localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
    localparam int KW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFFW        = $clog2(CACHE_LINE_WIDTH / 8);
    localparam logic [KW-1:0] LAST_K = KW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [CACHE_LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [CACHE_LINE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        rd_q, rd_d, wr_q, wr_d;
    logic                        resp_q, resp_d, err_q, err_d;
    logic                        pmem_err_s;

`ifdef CLADAPT_PMEM_ERROR_EN
    assign pmem_err_s = pmem_error;
`else
    logic unused_pmem_error;
    assign pmem_err_s        = 1'b0;
    assign unused_pmem_error = pmem_error;
`endif

    // Line-offset bits never reach memory; the burst is always line aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^address_i[OFFW-1:0];

    logic [BURST_WIDTH-1:0] wbeat [BURST_LEN];
    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            assign wbeat[gi] = wbuf_q[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    assign pmem_wdata = wbeat[k_q];
    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign pmem_addr  = addr_q;
    assign line_o     = line_q;
    assign resp_o     = resp_q;
    assign err_o      = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        line_d  = line_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (write_i || read_i) begin
                    addr_d = {address_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                    k_d    = '0;
                    if (write_i) begin
                        state_d = WR;
                        wr_d    = 1'b1;
                        wbuf_d  = line_i;
                    end else begin
                        state_d = RD;
                        rd_d    = 1'b1;
                    end
                end
            end
            RD, WR: begin
                if (pmem_err_s) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (pmem_resp) begin
                    k_d = k_q + 1'b1;
                    if (state_q == RD) begin
                        rbuf_d[k_q*BURST_WIDTH +: BURST_WIDTH] = pmem_rdata;
                    end
                    // Completion is registered on the last-beat edge so line_o is valid alongside resp_o.
                    if (k_q == LAST_K) begin
                        state_d = DONE;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        resp_d  = 1'b1;
                        if (state_q == RD) begin
                            line_d = rbuf_d;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and randomized bursts against a line-level model.
// Define CLADAPT_PMEM_ERROR_EN for both bench and RTL to exercise the error abort.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         read_i, write_i;
    logic [31:0]  address_i;
    logic [255:0] line_i, line_o;
    logic         resp_o, err_o, pmem_read, pmem_write;
    logic [31:0]  pmem_addr;
    logic [63:0]  pmem_wdata, pmem_rdata;
    logic         pmem_resp, pmem_error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] model_line_o;
    bit strobe_q[$];

    cacheline_adaptor dut (
        .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i),
        .address_i(address_i), .line_i(line_i), .line_o(line_o),
        .resp_o(resp_o), .err_o(err_o), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .pmem_error(pmem_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] beat_of(input logic [255:0] l, input int b);
        return l[64*b +: 64];
    endfunction

    // Runs one burst from IDLE (called at a negedge) using strobe_q as the memory strobe pattern.
    task automatic run_burst(input string name, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [255:0] wline,
                             input logic [255:0] rline);
        logic [31:0] exp_addr;
        int beat;
        logic is_wr;
        is_wr    = wr;
        exp_addr = addr & 32'hFFFF_FFE0;
        $display("txn %s rd=%0b wr=%0b addr=%h strobes=%0d", name, rd, wr, addr, strobe_q.size());
        read_i = rd; write_i = wr; address_i = addr; line_i = wline;
        @(negedge clk);
        n_cmp++; if (pmem_read !== !is_wr) begin n_bad++; $display("FAIL %s accept pmem_read got %b want %b", name, pmem_read, !is_wr); end
        n_cmp++; if (pmem_write !== is_wr) begin n_bad++; $display("FAIL %s accept pmem_write got %b want %b", name, pmem_write, is_wr); end
        n_cmp++; if (pmem_addr !== exp_addr) begin n_bad++; $display("FAIL %s pmem_addr got %h want %h", name, pmem_addr, exp_addr); end
        address_i = $urandom; line_i = rand_line();
        beat = 0;
        foreach (strobe_q[i]) begin
            if (is_wr) begin
                n_cmp++; if (pmem_wdata !== beat_of(wline, beat)) begin n_bad++; $display("FAIL %s wdata beat %0d got %h want %h", name, beat, pmem_wdata, beat_of(wline, beat)); end
            end
            pmem_resp  = strobe_q[i];
            pmem_rdata = strobe_q[i] ? beat_of(rline, beat) : {$urandom, $urandom};
            @(negedge clk);
            if (strobe_q[i]) beat++;
            if (beat < 4) begin
                n_cmp++; if (resp_o !== 1'b0) begin n_bad++; $display("FAIL %s early resp_o got %b want 0", name, resp_o); end
                n_cmp++; if ((is_wr ? pmem_write : pmem_read) !== 1'b1) begin n_bad++; $display("FAIL %s request dropped early at beat %0d got 0 want 1", name, beat); end
                n_cmp++; if (pmem_addr !== exp_addr) begin n_bad++; $display("FAIL %s pmem_addr held got %h want %h", name, pmem_addr, exp_addr); end
            end
        end
        pmem_resp = 1'b0;
        if (!is_wr) model_line_o = rline;
        n_cmp++; if (resp_o !== 1'b1) begin n_bad++; $display("FAIL %s resp_o got %b want 1", name, resp_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL %s err_o got %b want 0", name, err_o); end
        n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_bad++; $display("FAIL %s req after last beat got %b want 00", name, {pmem_read, pmem_write}); end
        n_cmp++; if (line_o !== model_line_o) begin n_bad++; $display("FAIL %s line_o got %h want %h", name, line_o, model_line_o); end
        read_i = 1'b0; write_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_o !== 1'b0) begin n_bad++; $display("FAIL %s resp_o second cycle got %b want 0", name, resp_o); end
        n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_bad++; $display("FAIL %s idle req got %b want 00", name, {pmem_read, pmem_write}); end
        n_cmp++; if (line_o !== model_line_o) begin n_bad++; $display("FAIL %s line_o hold got %h want %h", name, line_o, model_line_o); end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({resp_o, err_o, pmem_read, pmem_write} !== 4'b0 || pmem_addr !== 32'h0 || line_o !== 256'h0 || pmem_wdata !== 64'h0) begin
            n_bad++;
            $display("FAIL %s outputs got resp=%b err=%b rd=%b wr=%b addr=%h wdata=%h line_o=%h want all 0",
                     name, resp_o, err_o, pmem_read, pmem_write, pmem_addr, pmem_wdata, line_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; read_i = 0; write_i = 0; address_i = 0; line_i = 0;
        pmem_rdata = 0; pmem_resp = 0; pmem_error = 0; model_line_o = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_aligned_read();
        logic [255:0] rl;
        rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        strobe_q = {};
        repeat (10) strobe_q.push_back(1'b0);
        repeat (4) strobe_q.push_back(1'b1);
        run_burst("aligned_read", 1'b1, 1'b0, 32'h0000_1234, 256'h0, rl);
    endtask

    task automatic test_write();
        logic [255:0] wl;
        wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        for (int i = 0; i < 4; i++) wl[64*i +: 64] = {8{4'hA + 4'(i), 4'h0}};
        strobe_q = {};
        repeat (2) strobe_q.push_back(1'b0);
        repeat (4) strobe_q.push_back(1'b1);
        run_burst("write", 1'b0, 1'b1, 32'h0000_0080, wl, rand_line());
    endtask

    task automatic test_simultaneous();
        strobe_q = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        run_burst("simultaneous", 1'b1, 1'b1, $urandom, rand_line(), rand_line());
    endtask

    task automatic test_gapped();
        strobe_q = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_burst("gapped_read", 1'b1, 1'b0, $urandom, 256'h0, rand_line());
    endtask

    task automatic test_back_to_back();
        int op;
        for (int t = 0; t < 20; t++) begin
            strobe_q = {};
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 3)) strobe_q.push_back(1'b0);
                strobe_q.push_back(1'b1);
            end
            op = $urandom_range(0, 2);
            run_burst("random", (op != 1), (op != 0), $urandom, rand_line(), rand_line());
        end
    endtask

    task automatic test_reset_mid_burst();
        read_i = 1'b1; address_i = $urandom;
        $display("txn reset_mid_burst addr=%h", address_i);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_resp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_burst");
        read_i = 1'b0;
        model_line_o = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("post_reset_idle");
        end
        strobe_q = {1'b1, 1'b1, 1'b1, 1'b1};
        run_burst("after_abort", 1'b1, 1'b0, $urandom, 256'h0, rand_line());
    endtask

`ifdef CLADAPT_PMEM_ERROR_EN
    task automatic test_error();
        read_i = 1'b1; address_i = $urandom;
        $display("txn error_read addr=%h", address_i);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_error = 1'b1; pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_resp = 1'b0; pmem_error = 1'b0;
        n_cmp++; if ({resp_o, err_o} !== 2'b11) begin n_bad++; $display("FAIL error resp/err got %b want 11", {resp_o, err_o}); end
        n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL error pmem_read got %b want 0", pmem_read); end
        n_cmp++; if (line_o !== model_line_o) begin n_bad++; $display("FAIL error line_o got %h want %h", line_o, model_line_o); end
        read_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ({resp_o, err_o} !== 2'b00) begin n_bad++; $display("FAIL error clear resp/err got %b want 00", {resp_o, err_o}); end
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_read();
        test_write();
        test_simultaneous();
        test_gapped();
        test_back_to_back();
`ifdef CLADAPT_PMEM_ERROR_EN
        test_error();
`endif
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
